seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned WIDTH-bit dividend/divisor, one quotient bit per clock.
// The quotient and remainder are registered and change only when a division completes.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // dvd_q shifts dividend bits out at the MSB while quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             q_bit;

  // rem_shift < 2*divisor, so the WIDTH+1 bit difference never wraps and its MSB is the borrow
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    q_bit     = ~rem_sub[WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d = a;
          dvs_d = b;
          rem_d = '0;
          cnt_d = '0;
          if (b == '0) begin
            x_d    = '1;
            y_d    = a;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = StRun;
            busy_d  = 1'b1;
          end
        end
      end

      StRun: begin
        dvd_d = (dvd_q << 1) | WIDTH'(q_bit);
        rem_d = q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          x_d     = dvd_d;
          y_d     = rem_d;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on done.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, x, y;
  logic         busy, done, dbz;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   bad    = 0;
  int   n_done = 0;
  int   n_push = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] ex, input logic [W-1:0] ey, input logic ed);
    exp_t e;
    e.x   = ex;
    e.y   = ey;
    e.dbz = ed;
    sb.push_back(e);
    n_push++;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 x=%0d y=%0d expected no pending result", x, y);
      end else begin
        e = sb.pop_front();
        check("x", x, e.x);
        check("y", y, e.y);
        check("div_by_zero", dbz, e.dbz);
      end
    end
  end

  // Drive one start pulse; returns #1 after the accepting edge
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
  endtask

  task automatic run(input logic [W-1:0] va, input logic [W-1:0] vb,
                     input logic [W-1:0] ex, input logic [W-1:0] ey);
    push(ex, ey, 1'b0);
    issue(va, vb);
    wait_done("run");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] va, vb;
    int           n;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", dbz, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 100/7 with exact latency: busy for 8 cycles, done after the 8th RUN edge
    push(8'd14, 8'd2, 1'b0);
    issue(8'd100, 8'd7);
    check("busy_at_accept", busy, 1);
    check("done_at_accept", done, 0);
    for (int i = 1; i < W; i++) begin
      @(posedge clk);
      #1;
      check("busy_run", busy, 1);
      check("done_run", done, 0);
    end
    @(posedge clk);
    #1;
    check("done_latency", done, 1);
    check("busy_after", busy, 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);

    run(8'd255, 8'd1, 8'd255, 8'd0);
    run(8'd5,   8'd9, 8'd0,   8'd5);
    run(8'd0,   8'd3, 8'd0,   8'd0);

    // Divide by zero completes at the accepting edge without ever going busy
    push(8'd255, 8'd42, 1'b1);
    issue(8'd42, 8'd0);
    check("dbz_done", done, 1);
    check("dbz_busy", busy, 0);
    @(posedge clk);
    #1;
    check("dbz_done_after", done, 0);
    check("dbz_busy_after", busy, 0);
    run(8'd10, 8'd3, 8'd3, 8'd1);

    // A start during RUN is ignored and operand changes do not leak in
    push(8'd66, 8'd2, 1'b0);
    issue(8'd200, 8'd3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    wait_done("ignore");
    check("ignore_busy_after", busy, 0);

    // Asynchronous reset mid-cycle during RUN aborts with no done
    issue(8'd77, 8'd5);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_x", x, 0);
    check("abort_y", y, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dbz", dbz, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(8'd77, 8'd5, 8'd15, 8'd2);

    // Back-to-back sweep: start stays high, new operands presented in each done cycle
    va = W'($urandom_range(0, 255));
    vb = W'($urandom_range(1, 255));
    push(va / vb, va % vb, 1'b0);
    start = 1'b1;
    a     = va;
    b     = vb;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      n = 0;
      while (!done && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!done) begin
        total++;
        bad++;
        $display("FAIL sweep_timeout: got no done at item %0d expected done", i);
        break;
      end
      if (i < 999) begin
        va = W'($urandom_range(0, 255));
        vb = (i % 37 == 5) ? '0 : W'($urandom_range(1, 255));
        if (vb == '0) push('1, va, 1'b1);
        else push(va / vb, va % vb, 1'b0);
        a = va;
        b = vb;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    check("done_count", n_done, n_push);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
